// File: rtl/day_set_ctrl_pkg.sv
// Shared day codes, controller state encoding and day stepping helpers
// for the set-day feature.
package day_set_ctrl_pkg;

  localparam int unsigned DAY_W = 3;

  localparam logic [DAY_W-1:0] DAY_MON = 3'd0;
  localparam logic [DAY_W-1:0] DAY_TUE = 3'd1;
  localparam logic [DAY_W-1:0] DAY_WED = 3'd2;
  localparam logic [DAY_W-1:0] DAY_THU = 3'd3;
  localparam logic [DAY_W-1:0] DAY_FRI = 3'd4;
  localparam logic [DAY_W-1:0] DAY_SAT = 3'd5;
  localparam logic [DAY_W-1:0] DAY_SUN = 3'd6;

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } state_t;

  // Code 7 is unreachable; both helpers fold it back to monday.
  function automatic logic [DAY_W-1:0] day_inc(input logic [DAY_W-1:0] d);
    return (d >= DAY_SUN) ? DAY_MON : d + 3'd1;
  endfunction

  function automatic logic [DAY_W-1:0] day_dec(input logic [DAY_W-1:0] d);
    if (d == DAY_MON)
      return DAY_SUN;
    else if (d > DAY_SUN)
      return DAY_MON;
    else
      return d - 3'd1;
  endfunction

endpackage

// File: rtl/day_set_ctrl_edge_rise.sv
// Rising-edge detector: registered history, edge = level high now and low
// at the previous clock. History clears on reset.
module edge_rise (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_prev <= 1'b0;
    else
      r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/day_set_ctrl.sv
// Day-of-week controller: advances on midnight ticks in RUN, lets the user
// step the day with a blinking digit in SET, auto-returns to RUN when idle.
module day_set_ctrl
  import day_set_ctrl_pkg::*;
#(
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned TIMEOUT_CYC = 500000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             day_tick,
  output logic [DAY_W-1:0] day,
  output logic             blank,
  output logic             set_mode,
  output logic             week_wrap
);

  localparam int unsigned BW = $clog2(BLINK_DIV);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);

  state_t           r_state, w_state_nxt;
  logic [DAY_W-1:0] r_day, w_day_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic [BW-1:0]    r_blink_cnt, w_blink_cnt_nxt;
  logic             r_phase, w_phase_nxt;
  logic [TW-1:0]    r_to_cnt, w_to_cnt_nxt;
  logic             r_pending, w_pending_nxt;

  logic w_mode_e, w_up_e, w_dn_e;
  logic w_act, w_timeout, w_tick_eff;

  edge_rise u_edge_mode (.i_clk(clk), .i_rst(rst), .i_sig(btn_mode), .o_rise(w_mode_e));
  edge_rise u_edge_up   (.i_clk(clk), .i_rst(rst), .i_sig(btn_up),   .o_rise(w_up_e));
  edge_rise u_edge_dn   (.i_clk(clk), .i_rst(rst), .i_sig(btn_down), .o_rise(w_dn_e));

  // A mode edge in SET swallows any simultaneous up/down edge.
  assign w_act      = ~w_mode_e & (w_up_e | w_dn_e);
  assign w_timeout  = (r_to_cnt == TO_LAST) & ~w_act;
  assign w_tick_eff = day_tick | r_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_day       <= DAY_MON;
      r_wrap      <= 1'b0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
      r_to_cnt    <= '0;
      r_pending   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_day       <= w_day_nxt;
      r_wrap      <= w_wrap_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_pending   <= w_pending_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == RUN) begin
      if (w_mode_e)
        w_state_nxt = SET;
    end else begin
      if (w_mode_e || w_timeout)
        w_state_nxt = RUN;
    end
  end

  always_comb begin
    w_day_nxt       = r_day;
    w_wrap_nxt      = 1'b0;
    w_blink_cnt_nxt = r_blink_cnt;
    w_phase_nxt     = r_phase;
    w_to_cnt_nxt    = r_to_cnt;
    w_pending_nxt   = r_pending;
    if (r_state == RUN) begin
      // Counters sit at their entry values so SET always starts on-phase.
      w_blink_cnt_nxt = '0;
      w_phase_nxt     = 1'b1;
      w_to_cnt_nxt    = '0;
      w_pending_nxt   = 1'b0;
      if (w_tick_eff) begin
        w_day_nxt  = day_inc(r_day);
        w_wrap_nxt = (r_day == DAY_SUN);
      end
    end else begin
      if (day_tick)
        w_pending_nxt = 1'b1;
      if (w_act) begin
        if (w_up_e && !w_dn_e)
          w_day_nxt = day_inc(r_day);
        else if (w_dn_e && !w_up_e)
          w_day_nxt = day_dec(r_day);
        w_blink_cnt_nxt = '0;
        w_phase_nxt     = 1'b1;
        w_to_cnt_nxt    = '0;
      end else begin
        if (r_blink_cnt == BLINK_LAST) begin
          w_blink_cnt_nxt = '0;
          w_phase_nxt     = ~r_phase;
        end else begin
          w_blink_cnt_nxt = r_blink_cnt + 1'b1;
        end
        w_to_cnt_nxt = (r_to_cnt == TO_LAST) ? '0 : r_to_cnt + 1'b1;
      end
    end
  end

  assign day       = r_day;
  assign set_mode  = (r_state == SET);
  assign blank     = set_mode & ~r_phase;
  assign week_wrap = r_wrap;

endmodule

// File: tb/tb_day_set_ctrl.sv
// Bench for day_set_ctrl: directed vector table, timeout sequences and
// randomized traffic, all checked against an idle-count reference model.
module tb_day_set_ctrl;

  localparam int BLINK   = 4;
  localparam int TIMEOUT = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, day_tick = 1'b0;
  logic [2:0] day;
  logic       blank, set_mode, week_wrap;

  int n_checks = 0;
  int n_errors = 0;

  day_set_ctrl #(.BLINK_DIV(BLINK), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_down(btn_down), .day_tick(day_tick), .day(day), .blank(blank),
    .set_mode(set_mode), .week_wrap(week_wrap)
  );

  always #5 clk = ~clk;

  // Reference model: day as an integer mod 7, SET progress as one idle count
  // since entry or last step; blink phase and timeout derive from it.
  int m_day = 0, m_idle = 0;
  bit m_set = 0, m_pend = 0, m_wrap = 0;
  bit p_mode = 0, p_up = 0, p_dn = 0;

  function automatic int m_blank();
    return (m_set && ((m_idle / BLINK) % 2 == 1)) ? 1 : 0;
  endfunction

  task automatic model_step(input bit r, input bit m, input bit u, input bit d, input bit t);
    bit em, eu, ed;
    em = m & ~p_mode;
    eu = u & ~p_up;
    ed = d & ~p_dn;
    m_wrap = 0;
    if (r) begin
      m_day = 0; m_set = 0; m_pend = 0; m_idle = 0;
      p_mode = 0; p_up = 0; p_dn = 0;
    end else begin
      p_mode = m; p_up = u; p_dn = d;
      if (!m_set) begin
        if (t || m_pend) begin
          m_wrap = (m_day == 6);
          m_day  = (m_day + 1) % 7;
          m_pend = 0;
        end
        if (em) begin m_set = 1; m_idle = 0; end
      end else begin
        if (t) m_pend = 1;
        if (em) m_set = 0;
        else if (eu || ed) begin
          m_day  = (m_day + 7 + int'(eu) - int'(ed)) % 7;
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) m_set = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit m, input bit u, input bit d, input bit t);
    rst = r; btn_mode = m; btn_up = u; btn_down = d; day_tick = t;
    @(posedge clk);
    model_step(r, m, u, d, t);
    #1;
    check("model day", int'(day), m_day);
    check("model blank", int'(blank), m_blank());
    check("model set_mode", int'(set_mode), int'(m_set));
    check("model week_wrap", int'(week_wrap), int'(m_wrap));
  endtask

  typedef struct {
    bit r, m, u, d, t;
    int day;
    bit blank, set, wrap;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input bit m, input bit u, input bit d, input bit t,
                              input int dy, input bit bl, input bit st, input bit wr);
    vec_t v;
    v.r = r; v.m = m; v.u = u; v.d = d; v.t = t;
    v.day = dy; v.blank = bl; v.set = st; v.wrap = wr;
    tbl.push_back(v);
  endfunction

  initial begin
    bit lm, lu, ld;
    int act_div;

    // Reset and 8 midnight ticks in RUN
    add(1,0,0,0,0, 0,0,0,0);
    add(1,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0);
    for (int i = 1; i <= 8; i++) add(0,0,0,0,1, i % 7, 0, 0, i == 7);
    add(0,0,0,0,0, 1,0,0,0);
    // Enter SET, step down through monday, blink, step up in off phase
    add(1,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,0, 0,0,1,0);
    add(0,0,0,1,0, 6,0,1,0);
    add(0,0,0,0,0, 6,0,1,0);
    add(0,0,0,0,0, 6,0,1,0);
    add(0,0,0,0,0, 6,0,1,0);
    add(0,0,0,0,0, 6,1,1,0);
    add(0,0,0,0,0, 6,1,1,0);
    add(0,0,1,0,0, 0,0,1,0);
    add(0,0,0,0,0, 0,0,1,0);
    add(0,0,0,0,0, 0,0,1,0);
    add(0,0,0,0,0, 0,0,1,0);
    add(0,0,0,0,0, 0,1,1,0);
    // Up+down together, then mode+up together
    add(0,0,1,1,0, 0,0,1,0);
    add(0,0,0,0,0, 0,0,1,0);
    add(0,1,1,0,0, 0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0);
    // Pending ticks while in SET at sunday, merged with a fresh tick on return
    add(0,1,0,0,0, 0,0,1,0);
    add(0,0,0,0,0, 0,0,1,0);
    add(0,0,0,1,0, 6,0,1,0);
    add(0,0,0,0,1, 6,0,1,0);
    add(0,0,0,0,1, 6,0,1,0);
    add(0,0,0,0,1, 6,0,1,0);
    add(0,1,0,0,0, 6,0,0,0);
    add(0,0,0,0,1, 0,0,0,1);
    add(0,0,0,0,0, 0,0,0,0);
    // Tick on the cycle SET is entered is applied first
    add(0,1,0,0,1, 1,0,1,0);
    add(0,0,0,0,0, 1,0,1,0);
    // Reset mid-SET with pending tick, up held across reset
    add(0,0,1,0,0, 2,0,1,0);
    add(0,0,0,0,1, 2,0,1,0);
    add(1,0,1,0,0, 0,0,0,0);
    add(1,0,1,0,0, 0,0,0,0);
    add(0,0,1,0,0, 0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].r, tbl[i].m, tbl[i].u, tbl[i].d, tbl[i].t);
      check($sformatf("tbl[%0d] day", i), int'(day), tbl[i].day);
      check($sformatf("tbl[%0d] blank", i), int'(blank), int'(tbl[i].blank));
      check($sformatf("tbl[%0d] set_mode", i), int'(set_mode), int'(tbl[i].set));
      check($sformatf("tbl[%0d] week_wrap", i), int'(week_wrap), int'(tbl[i].wrap));
    end

    // Idle timeout: exit after the 32nd idle cycle
    cyc(0,1,0,0,0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      cyc(0,0,0,0,0);
      if (k == TIMEOUT - 1) check("timeout hold", int'(set_mode), 1);
      if (k == TIMEOUT) begin
        check("timeout exit", int'(set_mode), 0);
        check("timeout blank", int'(blank), 0);
      end
    end
    // A press at idle cycle 20 restarts the count: exit at 52
    cyc(0,1,0,0,0);
    for (int k = 1; k <= 52; k++) begin
      cyc(0, 0, (k == 20), 0, 0);
      if (k == 32) check("restart no early exit", int'(set_mode), 1);
      if (k == 51) check("restart hold", int'(set_mode), 1);
      if (k == 52) check("restart exit", int'(set_mode), 0);
    end

    // Randomized traffic; step-button activity alternates busy/quiet blocks
    lm = 0; lu = 0; ld = 0;
    for (int n = 0; n < 3000; n++) begin
      bit r, t;
      act_div = ((n / 200) % 2 == 0) ? 4 : 100;
      r = ($urandom_range(0, 399) == 0);
      t = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) lm = ~lm;
      if ($urandom_range(0, act_div - 1) == 0) lu = ~lu;
      if ($urandom_range(0, act_div - 1) == 0) ld = ~ld;
      cyc(r, lm, lu, ld, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
